// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer.
// Optional MULDIV_FAST_MUL_EN selects a single-cycle multiplier in muldiv_seq.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Fill bits: x/0 quotient is all ones, overflow remainder is all zeros.
  localparam logic DIVZ_Q_FILL = 1'b1;
  localparam logic OVF_R_FILL  = 1'b0;

  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV)  || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) ||
           (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply or
// restoring-division step over a shared {hi, lo} accumulator.
module muldiv_iter_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      i_is_div,
  input  logic [2*DATA_WIDTH-1:0]   i_acc,
  input  logic [DATA_WIDTH-1:0]     i_opnd,
  output logic [2*DATA_WIDTH-1:0]   o_acc
);

  localparam int W = DATA_WIDTH;

  logic [W:0] w_sum;
  logic [W:0] w_shl;
  logic [W:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_acc[2*W-1:W]}
           + (i_acc[0] ? {1'b0, i_opnd} : {(W+1){1'b0}});
    w_shl  = i_acc[2*W-1:W-1];
    w_diff = w_shl - {1'b0, i_opnd};
    if (!i_is_div)
      o_acc = {w_sum, i_acc[W-1:1]};
    else if (w_diff[W])
      o_acc = {w_shl[W-1:0], i_acc[W-2:0], 1'b0};
    else
      o_acc = {w_diff[W-1:0], i_acc[W-2:0], 1'b1};
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M MUL/DIV/REM sequencer for the EX stage, one bit per cycle.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_start,
  input  logic [2:0]            i_Funct3,
  input  logic [DATA_WIDTH-1:0] i_Read1,
  input  logic [DATA_WIDTH-1:0] i_Read2,
  input  logic                  i_kill,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [DATA_WIDTH-1:0] o_Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2*W-1:0]   r_acc;
  logic [W-1:0]     r_opnd;
  logic [2:0]       r_f3;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_done;
  logic [W-1:0]     r_result;

  logic             w_s1, w_s2;
  logic [W-1:0]     w_mag1, w_mag2;
  logic             w_divz, w_ovf;
  logic [W-1:0]     w_spec_res;
  logic [2*W-1:0]   w_step;
  logic [2*W-1:0]   w_prod;
  logic [W-1:0]     w_quot, w_rem;
  logic [W-1:0]     w_fix_res;

  assign w_s1   = rs1_signed(i_Funct3) & i_Read1[W-1];
  assign w_s2   = rs2_signed(i_Funct3) & i_Read2[W-1];
  assign w_mag1 = w_s1 ? -i_Read1 : i_Read1;
  assign w_mag2 = w_s2 ? -i_Read2 : i_Read2;

  assign w_divz = i_Funct3[2] & (i_Read2 == '0);
  assign w_ovf  = ((i_Funct3 == F3_DIV) || (i_Funct3 == F3_REM))
                & (i_Read1 == {1'b1, {(W-1){1'b0}}})
                & (i_Read2 == '1);

  // Overflow quotient equals rs1 (the most negative value).
  assign w_spec_res = w_divz
    ? (i_Funct3[1] ? i_Read1 : {W{DIVZ_Q_FILL}})
    : (i_Funct3[1] ? {W{OVF_R_FILL}} : i_Read1);

  muldiv_iter_step #(.DATA_WIDTH(W)) u_step (
    .i_is_div (r_f3[2]),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step)
  );

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_comb begin
    w_fix_res = w_rem;
    unique case (r_f3)
      F3_MUL:                       w_fix_res = w_prod[W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix_res = w_prod[2*W-1:W];
      F3_DIV, F3_DIVU:              w_fix_res = w_quot;
      default:                      w_fix_res = w_rem;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*W-1:0] w_fa, w_fb, w_fp;
  logic [W-1:0]          w_fast_res;
  assign w_fa = {{W{rs1_signed(i_Funct3) & i_Read1[W-1]}}, i_Read1};
  assign w_fb = {{W{rs2_signed(i_Funct3) & i_Read2[W-1]}}, i_Read2};
  assign w_fp = w_fa * w_fb;
  assign w_fast_res = (i_Funct3 == F3_MUL) ? w_fp[W-1:0] : w_fp[2*W-1:W];
`endif

  assign o_Busy = ((r_state == S_IDLE) & i_start & ~i_kill)
                | (r_state == S_CALC) | (r_state == S_FIX);
  assign o_Done   = r_done;
  assign o_Result = r_result;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_f3     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (i_kill) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_f3    <= i_Funct3;
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;
            r_cnt   <= CW'(W);
            r_acc   <= {{W{1'b0}}, w_mag1};
            r_opnd  <= w_mag2;
            if (w_divz || w_ovf) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!i_Funct3[2]) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
`endif
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed vector bench for muldiv_seq: results, latency, kill, reset.
// Multiply latency expectation follows MULDIV_FAST_MUL_EN.
module tb_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 34;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_start;
  logic [2:0]  i_Funct3;
  logic [31:0] i_Read1, i_Read2;
  logic        i_kill;
  logic        o_Busy, o_Done;
  logic [31:0] o_Result;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_start  (i_start),
    .i_Funct3 (i_Funct3),
    .i_Read1  (i_Read1),
    .i_Read2  (i_Read2),
    .i_kill   (i_kill),
    .o_Busy   (o_Busy),
    .o_Done   (o_Done),
    .o_Result (o_Result)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res,
                       output int lat, output int busy,
                       output logic dup);
    @(negedge clk);
    i_Funct3 = f3;
    i_Read1  = a;
    i_Read2  = b;
    i_start  = 1'b1;
    lat  = -1;
    busy = 0;
    res  = 'x;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (o_Busy) busy++;
      if (o_Done) begin
        lat = c;
        res = o_Result;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    i_start = 1'b0;
    #1;
    dup = o_Done;
  endtask

  logic [31:0] res;
  int          lat, busy, ndone;
  logic        dup;

  initial begin
    vt[0]  = '{3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, ML};
    vt[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML};
    vt[2]  = '{3'b010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, ML};
    vt[3]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, ML};
    vt[4]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        ML};
    vt[5]  = '{3'b000, 32'h12345678, 32'h10,       32'h23456780, ML};
    vt[6]  = '{3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34};
    vt[7]  = '{3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 34};
    vt[8]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34};
    vt[9]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34};
    vt[10] = '{3'b100, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vt[11] = '{3'b110, 32'h7,        32'hFFFFFFFE, 32'h1,        34};
    vt[12] = '{3'b101, 32'd5,        32'h0,        32'hFFFFFFFF, 1};
    vt[13] = '{3'b110, 32'd5,        32'h0,        32'd5,        1};
    vt[14] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vt[15] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
    vt[16] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0,        34};
    vt[17] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
    vt[18] = '{3'b101, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 34};

    n_rst    = 1'b0;
    i_start  = 1'b0;
    i_kill   = 1'b0;
    i_Funct3 = '0;
    i_Read1  = '0;
    i_Read2  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy",   {31'b0, o_Busy},  32'h0);
    chk("reset_done",   {31'b0, o_Done},  32'h0);
    chk("reset_result", o_Result,         32'h0);
    n_rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      do_op(vt[i].f3, vt[i].a, vt[i].b, res, lat, busy, dup);
      chk($sformatf("v%0d_result", i),  res,         vt[i].exp);
      chk($sformatf("v%0d_latency", i), 32'(lat),    32'(vt[i].lat));
      chk($sformatf("v%0d_busy", i),    32'(busy),   32'(vt[i].lat));
      chk($sformatf("v%0d_one_done", i), {31'b0, dup}, 32'h0);
    end

    // Kill in CALC cycle 10: result must keep vt[18].exp.
    @(negedge clk);
    i_Funct3 = 3'b101;
    i_Read1  = 32'd1000;
    i_Read2  = 32'd3;
    i_start  = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("kill_busy_calc", {31'b0, o_Busy}, 32'h1);
    i_kill  = 1'b1;
    i_start = 1'b0;
    @(negedge clk);
    i_kill = 1'b0;
    #1;
    chk("kill_busy",   {31'b0, o_Busy}, 32'h0);
    chk("kill_done",   {31'b0, o_Done}, 32'h0);
    chk("kill_result", o_Result,        vt[18].exp);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (o_Done) ndone++;
    end
    chk("kill_no_done", 32'(ndone), 32'h0);

    do_op(3'b101, 32'd1000, 32'd3, res, lat, busy, dup);
    chk("after_kill_result",  res,      32'd333);
    chk("after_kill_latency", 32'(lat), 32'd34);

    // Kill and start together in IDLE: kill wins.
    @(negedge clk);
    i_Funct3 = 3'b101;
    i_Read1  = 32'd9;
    i_Read2  = 32'd2;
    i_start  = 1'b1;
    i_kill   = 1'b1;
    #1;
    chk("kill_start_busy", {31'b0, o_Busy}, 32'h0);
    @(negedge clk);
    i_start = 1'b0;
    i_kill  = 1'b0;
    #1;
    chk("kill_start_idle", {31'b0, o_Busy}, 32'h0);
    chk("kill_start_done", {31'b0, o_Done}, 32'h0);
    chk("kill_start_res",  o_Result,        32'd333);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    i_Funct3 = 3'b000;
    i_Read1  = 32'h7;
    i_Read2  = 32'hFFFFFFFD;
    i_start  = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    n_rst   = 1'b0;
    i_start = 1'b0;
    #1;
    chk("rst_mid_busy",   {31'b0, o_Busy}, 32'h0);
    chk("rst_mid_done",   {31'b0, o_Done}, 32'h0);
    chk("rst_mid_result", o_Result,        32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    do_op(3'b101, 32'd100, 32'd7, res, lat, busy, dup);
    chk("after_rst_result",  res,      32'd14);
    chk("after_rst_latency", 32'(lat), 32'd34);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
